seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder_pkg.sv | 27 ++
 rtl/seg_scan_decoder_lut.sv | 14 +
 rtl/seg_scan_decoder.sv | 156 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared 7-segment definitions: active-low glyph table, blank pattern,
// scan FSM states and the pattern-to-nibble lookup function.
package seg_pkg;

    // Index is the hex value, entry is the active-low g..a pattern.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} scan_state_e;

    // Returns {legal, nibble}; nibble is 0 when the pattern is not a glyph.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg7);
        logic [4:0] result;
        result = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg7 == SEG_PATTERNS[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_lut.sv
// Combinational active-low 7-segment pattern to {legal, nibble} lookup.
module seg_pattern_lut
    import seg_pkg::*;
(
    input  logic [6:0] seg7,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        {legal, nibble} = seg_to_hex(seg7);
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-bus sniffer: recovers per-digit hex/dp once a digit's pattern is stable.
// Define SEG_BLANK_EN to accept the all-segments-off pattern as a legal blank.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] hex,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic                    err,
    output logic                    frame_done
);

    localparam int SAMPLE_W = 8 + NUM_DIGITS;

    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [SAMPLE_W-1:0]   prev_q;
    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic                  err_q, err_d;
    logic                  frame_done_q, frame_done_d;

    logic       one_hot;
    logic       changed;
    logic       capture;
    logic       store;
    logic       blank;
    logic       lut_legal;
    logic [3:0] lut_nibble;

    seg_pattern_lut u_lut (
        .seg7   (seg_q[6:0]),
        .legal  (lut_legal),
        .nibble (lut_nibble)
    );

`ifdef SEG_BLANK_EN
    assign blank = (seg_q[6:0] == SEG_BLANK);
`else
    assign blank = 1'b0;
`endif

    assign one_hot = $onehot(~an_q);
    assign changed = ({seg_q, an_q} != prev_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!one_hot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == HOLD && !changed) begin
            state_d = HOLD;
        end else begin
            // Entering from IDLE or seeing a new sample starts a fresh run.
            cnt_d = (state_q == IDLE || changed) ? CNT_W'(1) : cnt_q + 1'b1;
            if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
                capture = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = TRACK;
            end
        end
    end

    assign store = capture & (lut_legal | blank);

    always_comb begin
        frame_done_d = &mask_q;
        err_d        = capture & ~lut_legal & ~blank;
        // A completed mask clears before the new digit's bit is recorded.
        mask_d       = (frame_done_d ? '0 : mask_q) | (store ? ~an_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= 8'hFF;
            an_q         <= '1;
            prev_q       <= {8'hFF, {NUM_DIGITS{1'b1}}};
            state_q      <= IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg;
            an_q         <= an;
            prev_q       <= {seg_q, an_q};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] hex_q, hex_d;
            logic       dp_q, dp_d;
            logic       valid_q, valid_d;
            logic       hit;

            assign hit = capture & ~an_q[gi];

            always_comb begin
                hex_d   = hex_q;
                dp_d    = dp_q;
                valid_d = valid_q;
                if (hit) begin
                    if (lut_legal) begin
                        hex_d   = lut_nibble;
                        dp_d    = ~seg_q[7];
                        valid_d = 1'b1;
                    end else if (blank) begin
                        hex_d   = 4'd0;
                        dp_d    = ~seg_q[7];
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hex_q   <= 4'd0;
                    dp_q    <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    hex_q   <= hex_d;
                    dp_q    <= dp_d;
                    valid_q <= valid_d;
                end
            end

            assign hex[4*gi +: 4] = hex_q;
            assign dp[gi]         = dp_q;
            assign valid[gi]      = valid_q;
        end
    endgenerate

    assign err        = err_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized self-checking bench for seg_scan_decoder against a run-length model.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] hex;
    logic [ND-1:0] dp;
    logic [ND-1:0] valid;
    logic          err;
    logic          frame_done;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .hex        (hex),
        .dp         (dp),
        .valid      (valid),
        .err        (err),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyphs, active-low g..a, indexed by the displayed hex value.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_checks = 0;
    int n_fail   = 0;
    int n_err_seen = 0;
    int n_fd_seen  = 0;

    // Model: a digit is captured when its sample has repeated exactly SC times.
    logic [3:0]    m_hex [ND];
    logic [ND-1:0] m_dp, m_valid, m_mask;
    logic          m_err, m_fd;
    logic [11:0]   m_pend, m_last;
    int            m_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == p) return {1'b1, 4'(i)};
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_hex[i] = 4'd0;
        m_dp = '0; m_valid = '0; m_mask = '0;
        m_err = 1'b0; m_fd = 1'b0;
        m_pend = {8'hFF, 4'hF};
        m_last = {8'hFF, 4'hF};
        m_run = 0;
    endtask

    task automatic model_edge(input logic [11:0] cur);
        logic [7:0] s_seg;
        logic [3:0] s_an;
        logic [4:0] dec;
        logic       is_blank;
        int         d;
        s_seg = m_pend[11:4];
        s_an  = m_pend[3:0];
        m_run = (m_pend == m_last) ? m_run + 1 : 1;
        m_last = m_pend;
        m_fd = (m_mask == 4'hF);
        if (m_fd) m_mask = '0;
        m_err = 1'b0;
        if ($countones(~s_an) == 1 && m_run == SC) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (!s_an[i]) d = i;
            dec = ref_decode(s_seg[6:0]);
`ifdef SEG_BLANK_EN
            is_blank = (s_seg[6:0] == 7'h7F);
`else
            is_blank = 1'b0;
`endif
            if (dec[4]) begin
                m_hex[d] = dec[3:0]; m_dp[d] = ~s_seg[7]; m_valid[d] = 1'b1; m_mask[d] = 1'b1;
            end else if (is_blank) begin
                m_hex[d] = 4'd0; m_dp[d] = ~s_seg[7]; m_valid[d] = 1'b0; m_mask[d] = 1'b1;
            end else begin
                m_valid[d] = 1'b0; m_err = 1'b1;
            end
        end
        m_pend = cur;
    endtask

    task automatic compare_all();
        chk("hex", 32'(hex), 32'({m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("err", 32'(err), 32'(m_err));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        if (err) n_err_seen++;
        if (frame_done) n_fd_seen++;
    endtask

    task automatic step(input logic [7:0] s, input logic [3:0] a);
        seg = s;
        an  = a;
        @(posedge clk);
        model_edge({s, a});
        @(negedge clk);
        compare_all();
        $display("step seg=%02h an=%b hex=%04h dp=%b valid=%b err=%b fd=%b",
                 s, a, hex, dp, valid, err, frame_done);
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) step(s, a);
    endtask

    initial begin
        int err0, fd0, kind, dig, len;
        logic [7:0] pat;
        logic [3:0] anv;

        rst_n = 1'b0;
        seg = 8'hFF;
        an  = 4'hF;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({hex, dp, valid, err, frame_done}), 32'd0);
        rst_n = 1'b1;

        // Single digit capture after the stability window.
        hold(8'hC0, 4'b1110, 5);
        chk("tp1_valid", 32'(valid), 32'h1);
        chk("tp1_hex0", 32'(hex[3:0]), 32'h0);
        chk("tp1_dp0", 32'(dp[0]), 32'h0);

        // Four-digit scan including a blank-with-dp on digit 2.
        err0 = n_err_seen; fd0 = n_fd_seen;
        hold(8'h99, 4'b1110, 6);
        hold(8'hA4, 4'b1101, 6);
        hold(8'h7F, 4'b1011, 6);
        hold(8'h8E, 4'b0111, 6);
        hold(8'hFF, 4'b1111, 2);
        chk("tp2_valid", 32'(valid), 32'hB);
        chk("tp2_hex3", 32'(hex[15:12]), 32'hF);
        chk("tp2_hex10", 32'(hex[7:0]), 32'h24);
`ifdef SEG_BLANK_EN
        chk("tp2_err_cnt", 32'(n_err_seen - err0), 32'd0);
        chk("tp2_dp2", 32'(dp[2]), 32'd1);
        chk("tp2_fd_cnt", 32'(n_fd_seen - fd0), 32'd1);
`else
        chk("tp2_err_cnt", 32'(n_err_seen - err0), 32'd1);
        chk("tp2_fd_cnt", 32'(n_fd_seen - fd0), 32'd0);
`endif

        // Short glitch must not be captured.
        hold(8'h80, 4'b1101, 3);
        hold(8'hF9, 4'b1101, 5);
        chk("glitch_hex1", 32'(hex[7:4]), 32'h1);

        // Two digits selected at once: nothing happens.
        err0 = n_err_seen;
        hold(8'hC0, 4'b1100, 10);
        chk("multi_err_cnt", 32'(n_err_seen - err0), 32'd0);

        // Two full legal frames.
        fd0 = n_fd_seen;
        hold(8'hFF, 4'hF, 2);
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < ND; d++) begin
                anv = 4'hF;
                anv[d] = 1'b0;
                hold({1'($urandom_range(0, 1)), GLYPH[$urandom_range(0, 15)]}, anv, 6);
            end
        end
        hold(8'hFF, 4'hF, 2);
        chk("two_frames_fd", 32'(n_fd_seen - fd0), 32'd2);

        // Reset during tracking at count 2.
        hold(8'h92, 4'b1011, 3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({hex, dp, valid, err, frame_done}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(8'h92, 4'b1011, SC);
        chk("post_reset_wait", 32'(valid), 32'd0);
        step(8'h92, 4'b1011);
        chk("post_reset_cap", 32'(valid), 32'h4);

        // Randomized scan traffic.
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 9);
            dig  = $urandom_range(0, ND - 1);
            len  = $urandom_range(1, 7);
            anv  = 4'hF;
            anv[dig] = 1'b0;
            pat  = {1'($urandom_range(0, 1)), GLYPH[$urandom_range(0, 15)]};
            if (kind == 7) pat[6:0] = 7'($urandom);
            if (kind == 8) pat[6:0] = 7'h7F;
            if (kind == 9) anv = 4'($urandom);
            hold(pat, anv, len);
        end
        hold(8'hFF, 4'hF, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
